// File: rtl/mesi_snoop_responder.sv
// Snoop-side MESI responder: looks up the local line-state store for each bus
// snoop, reports NOHIT/HIT/HITM, writes back dirty lines and downgrades/invalidates.
module mesi_snoop_responder #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   snp_valid,
    output logic                   snp_ready,
    input  logic [1:0]             snp_op,
    input  logic [TAG_W+IDX_W-1:0] snp_addr,
    output logic                   snp_resp_valid,
    output logic [1:0]             snp_result,
    output logic                   wb_valid,
    output logic [TAG_W+IDX_W-1:0] wb_addr,
    input  logic                   wb_ready,
    input  logic                   fill_valid,
    output logic                   fill_ready,
    input  logic [TAG_W+IDX_W-1:0] fill_addr,
    input  logic [1:0]             fill_state,
    input  logic [TAG_W+IDX_W-1:0] dbg_addr,
    output logic [1:0]             dbg_state,
    output logic                   proto_err
);
    localparam int          AW    = TAG_W + IDX_W;
    localparam int unsigned LINES = 1 << IDX_W;

    typedef enum logic [1:0] {ST_IDLE, ST_LOOKUP, ST_WB, ST_RESP} fsm_t;
    typedef enum logic [1:0] {LS_M = 2'd0, LS_E = 2'd1, LS_S = 2'd2, LS_I = 2'd3} line_t;
    typedef enum logic [1:0] {OP_READ = 2'd0, OP_WRITE = 2'd1, OP_RFO = 2'd2, OP_INV = 2'd3} op_t;
    typedef enum logic [1:0] {RES_NOHIT = 2'd0, RES_HIT = 2'd1, RES_HITM = 2'd2} res_t;

    fsm_t             state, state_nx;
    logic [TAG_W-1:0] tag_mem  [LINES];
    line_t            line_mem [LINES];

    op_t              op_q;
    logic [AW-1:0]    addr_q;
    res_t             pend_res;
    line_t            pend_st;
    logic             pend_err;
    res_t             result_q;
    logic [AW-1:0]    wb_addr_q;
    logic             proto_err_q;

    logic [IDX_W-1:0] idx_q;
    logic [TAG_W-1:0] tag_q;
    line_t            cur_st;
    logic             hit;
    res_t             res_nx;
    line_t            upd_nx;
    logic             err_nx;

    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] dbg_idx;
    logic [TAG_W-1:0] dbg_tag;

    assign idx_q    = addr_q[IDX_W-1:0];
    assign tag_q    = addr_q[AW-1:IDX_W];
    assign cur_st   = line_mem[idx_q];
    assign hit      = (tag_mem[idx_q] == tag_q) && (cur_st != LS_I);
    assign fill_idx = fill_addr[IDX_W-1:0];
    assign fill_tag = fill_addr[AW-1:IDX_W];
    assign dbg_idx  = dbg_addr[IDX_W-1:0];
    assign dbg_tag  = dbg_addr[AW-1:IDX_W];

    always_comb begin
        res_nx = RES_NOHIT;
        upd_nx = cur_st;
        err_nx = 1'b0;
        if (hit) begin
            case (op_q)
                OP_READ: begin
                    upd_nx = LS_S;
                    res_nx = (cur_st == LS_M) ? RES_HITM : RES_HIT;
                end
                OP_RFO: begin
                    upd_nx = LS_I;
                    res_nx = (cur_st == LS_M) ? RES_HITM : RES_HIT;
                end
                OP_INV: begin
                    upd_nx = LS_I;
                    if (cur_st == LS_S) res_nx = RES_HIT;
                    else                err_nx = 1'b1;
                end
                default: begin
                    if (cur_st == LS_M) err_nx = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (snp_valid) state_nx = ST_LOOKUP;
            ST_LOOKUP: state_nx = (res_nx == RES_HITM) ? ST_WB : ST_RESP;
            ST_WB:     if (wb_ready) state_nx = ST_RESP;
            default:   state_nx = ST_IDLE;
        endcase
    end

    assign snp_ready      = (state == ST_IDLE);
    assign fill_ready     = snp_ready && !snp_valid;
    assign wb_valid       = (state == ST_WB);
    assign wb_addr        = wb_addr_q;
    assign snp_resp_valid = (state == ST_RESP);
    assign snp_result     = result_q;
    assign proto_err      = proto_err_q;
    assign dbg_state      = ((tag_mem[dbg_idx] == dbg_tag) && (line_mem[dbg_idx] != LS_I))
                            ? line_mem[dbg_idx] : LS_I;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            op_q        <= OP_READ;
            addr_q      <= '0;
            pend_res    <= RES_NOHIT;
            pend_st     <= LS_I;
            pend_err    <= 1'b0;
            result_q    <= RES_NOHIT;
            wb_addr_q   <= '0;
            proto_err_q <= 1'b0;
            for (int unsigned i = 0; i < LINES; i++) begin
                tag_mem[i]  <= '0;
                line_mem[i] <= LS_I;
            end
        end else begin
            state <= state_nx;
            if (snp_valid && snp_ready) begin
                op_q   <= op_t'(snp_op);
                addr_q <= snp_addr;
            end
            if (state == ST_LOOKUP) begin
                pend_res <= res_nx;
                pend_st  <= upd_nx;
                pend_err <= err_nx;
                if (res_nx == RES_HITM) wb_addr_q <= addr_q;
            end
            // Result register only changes on entry to RESP so it holds between responses.
            if (state_nx == ST_RESP)
                result_q <= (state == ST_LOOKUP) ? res_nx : pend_res;
            if (state == ST_RESP) begin
                line_mem[idx_q] <= pend_st;
                if (pend_err) proto_err_q <= 1'b1;
            end else if (fill_valid && fill_ready) begin
                tag_mem[fill_idx]  <= fill_tag;
                line_mem[fill_idx] <= line_t'(fill_state);
            end
        end
    end
endmodule

// File: tb/tb_mesi_snoop_responder.sv
// Scoreboard bench for mesi_snoop_responder: directed snoops/fills push expected
// responses and writebacks; a negedge monitor pops and compares them.
module tb_mesi_snoop_responder;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          snp_valid = 1'b0;
    logic          snp_ready;
    logic [1:0]    snp_op = 2'd0;
    logic [AW-1:0] snp_addr = '0;
    logic          snp_resp_valid;
    logic [1:0]    snp_result;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic          wb_ready = 1'b1;
    logic          fill_valid = 1'b0;
    logic          fill_ready;
    logic [AW-1:0] fill_addr = '0;
    logic [1:0]    fill_state = 2'd3;
    logic [AW-1:0] dbg_addr = '0;
    logic [1:0]    dbg_state;
    logic          proto_err;

    mesi_snoop_responder #(.IDX_W(4), .TAG_W(8)) dut (
        .clk(clk), .rst(rst),
        .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
        .snp_resp_valid(snp_resp_valid), .snp_result(snp_result),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_ready(wb_ready),
        .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_addr(fill_addr),
        .fill_state(fill_state), .dbg_addr(dbg_addr), .dbg_state(dbg_state),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [1:0] res; int cyc;} resp_t;
    typedef struct {logic [AW-1:0] addr; int cyc;} wb_t;
    resp_t resp_q[$];
    wb_t   wb_q[$];
    resp_t er;
    wb_t   ew;
    logic  wb_prev = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic exp_resp(input logic [1:0] res, input int c);
        resp_t e;
        e.res = res; e.cyc = c;
        resp_q.push_back(e);
    endtask

    task automatic exp_wb(input logic [AW-1:0] a, input int c);
        wb_t e;
        e.addr = a; e.cyc = c;
        wb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && snp_resp_valid) begin
            if (resp_q.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
            else begin
                er = resp_q.pop_front();
                check("resp_result", {30'd0, snp_result}, {30'd0, er.res});
                check("resp_cycle", cyc, er.cyc);
            end
        end
        if (wb_valid && !wb_prev) begin
            if (wb_q.size() == 0) check("unexpected_wb", 32'd1, 32'd0);
            else begin
                ew = wb_q.pop_front();
                check("wb_addr", {20'd0, wb_addr}, {20'd0, ew.addr});
                check("wb_cycle", cyc, ew.cyc);
            end
        end
        wb_prev = wb_valid;
    end

    task automatic do_fill(input logic [AW-1:0] a, input logic [1:0] s);
        fill_valid = 1'b1; fill_addr = a; fill_state = s;
        @(posedge clk); #1;
        fill_valid = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [1:0] res,
                         input int lat, input bit push, output int c);
        c = cyc;
        snp_valid = 1'b1; snp_op = op; snp_addr = a;
        if (push) exp_resp(res, c + lat);
        @(posedge clk); #1;
        snp_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (resp_q.size() == 0 && snp_ready) begin ok = 1'b1; break; end
        end
        check("drain_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic dbg(input string name, input logic [AW-1:0] a, input logic [1:0] exp);
        dbg_addr = a;
        #1 check(name, {30'd0, dbg_state}, {30'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int fc;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'd0, snp_resp_valid}, 32'd0);
        check("rst_result", {30'd0, snp_result}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_addr", {20'd0, wb_addr}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_snp_ready", {31'd0, snp_ready}, 32'd1);
        dbg("rst_dbg_035", 12'h035, 2'd3);

        // M line, READ with delayed wb_ready: WB at 2, response at 5 HITM, line -> S
        do_fill(12'h035, 2'd0);
        dbg("fill_dbg_035", 12'h035, 2'd0);
        wb_ready = 1'b0;
        issue(2'd0, 12'h035, 2'd2, 5, 1'b1, c);
        exp_wb(12'h035, c + 2);
        repeat (3) @(posedge clk);
        #1;
        check("wb_hold_valid", {31'd0, wb_valid}, 32'd1);
        check("wb_hold_addr", {20'd0, wb_addr}, 32'h035);
        wb_ready = 1'b1;
        wait_idle();
        dbg("read_m_dbg", 12'h035, 2'd2);
        check("result_held", {30'd0, snp_result}, 32'd2);

        // E line, RFO: HIT at 2, no writeback, line -> I
        do_fill(12'h012, 2'd1);
        issue(2'd2, 12'h012, 2'd1, 2, 1'b1, c);
        wait_idle();
        dbg("rfo_e_dbg", 12'h012, 2'd3);

        // Same index, different tag: miss
        do_fill(12'h012, 2'd2);
        issue(2'd0, 12'h022, 2'd0, 2, 1'b1, c);
        wait_idle();
        dbg("miss_dbg_012", 12'h012, 2'd2);
        dbg("miss_dbg_022", 12'h022, 2'd3);

        // INVALIDATE on E: NOHIT, sticky proto_err
        do_fill(12'h040, 2'd1);
        check("pre_proto_err", {31'd0, proto_err}, 32'd0);
        issue(2'd3, 12'h040, 2'd0, 2, 1'b1, c);
        wait_idle();
        check("inv_e_proto_err", {31'd0, proto_err}, 32'd1);
        dbg("inv_e_dbg", 12'h040, 2'd3);
        issue(2'd0, 12'h040, 2'd0, 2, 1'b1, c);
        wait_idle();
        check("sticky_proto_err", {31'd0, proto_err}, 32'd1);

        // INVALIDATE on S: HIT, line -> I
        issue(2'd3, 12'h035, 2'd1, 2, 1'b1, c);
        wait_idle();
        dbg("inv_s_dbg", 12'h035, 2'd3);

        // WRITE on M: NOHIT, no change; then RFO on M with wb_ready high: response at 3
        do_fill(12'h057, 2'd0);
        issue(2'd1, 12'h057, 2'd0, 2, 1'b1, c);
        wait_idle();
        dbg("write_m_dbg", 12'h057, 2'd0);
        issue(2'd2, 12'h057, 2'd2, 3, 1'b1, c);
        exp_wb(12'h057, c + 2);
        wait_idle();
        dbg("rfo_m_dbg", 12'h057, 2'd3);

        // Snoop and fill together: snoop wins, fill accepted once back in IDLE (cycle 3)
        c = cyc;
        fill_valid = 1'b1; fill_addr = 12'h061; fill_state = 2'd1;
        snp_valid = 1'b1; snp_op = 2'd0; snp_addr = 12'h061;
        exp_resp(2'd0, c + 2);
        #1 check("collide_fill_ready", {31'd0, fill_ready}, 32'd0);
        check("collide_snp_ready", {31'd0, snp_ready}, 32'd1);
        @(posedge clk); #1;
        snp_valid = 1'b0;
        fc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fill_ready) begin fc = cyc; break; end
        end
        check("fill_after_snoop_cycle", fc, c + 3);
        @(posedge clk); #1;
        fill_valid = 1'b0;
        dbg("collide_fill_dbg", 12'h061, 2'd1);
        wait_idle();

        // Reset while stalled in WB: wb_valid drops at once, lines cleared, no response
        do_fill(12'h07A, 2'd0);
        wb_ready = 1'b0;
        issue(2'd2, 12'h07A, 2'd0, 0, 1'b0, c);
        exp_wb(12'h07A, c + 2);
        @(posedge clk); #1;
        check("pre_rst_wb_valid", {31'd0, wb_valid}, 32'd1);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("abort_resp_valid", {31'd0, snp_resp_valid}, 32'd0);
        check("abort_proto_err", {31'd0, proto_err}, 32'd0);
        dbg("abort_dbg_07a", 12'h07A, 2'd3);
        dbg("abort_dbg_012", 12'h012, 2'd3);
        dbg("abort_dbg_061", 12'h061, 2'd3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wb_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_idle", {31'd0, snp_ready}, 32'd1);
        check("resp_queue_empty", resp_q.size(), 32'd0);
        check("wb_queue_empty", wb_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
